// File: rtl/eq_pkg_amisha.sv
// Shared types for the serial N-bit equality comparator.
package eq_pkg_amisha;

  localparam int EQ_N_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } eq_state_e;

endpackage

// File: rtl/eq1_cell_amisha.sv
// Single-bit equality cell: high when both inputs carry the same value.
module eq1_cell_amisha (
  input  logic a_i,
  input  logic b_i,
  output logic eq_o
);

  assign eq_o = ~(a_i ^ b_i);

endmodule

// File: rtl/eqn_serial_amisha.sv
// Serial N-bit equality comparator: scans LSB first, exits on the first mismatching bit.
module eqn_serial_amisha
  import eq_pkg_amisha::*;
#(
  parameter int N = EQ_N_DEFAULT
) (
  input  logic                 clk_amisha,
  input  logic                 reset_amisha,
  input  logic                 start_amisha,
  input  logic [N-1:0]         a_amisha,
  input  logic [N-1:0]         b_amisha,
  output logic                 busy_amisha,
  output logic                 done_amisha,
  output logic                 eq_amisha,
  output logic [$clog2(N)-1:0] idx_amisha
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_BIT = IW'(N - 1);

  eq_state_e     state_q, state_d;
  logic [N-1:0]  sr_a_q, sr_a_d;
  logic [N-1:0]  sr_b_q, sr_b_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          eq_q, eq_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          bit_eq;

  eq1_cell_amisha u_eq1 (
    .a_i  (sr_a_q[0]),
    .b_i  (sr_b_q[0]),
    .eq_o (bit_eq)
  );

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_amisha) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!bit_eq || (cnt_q == LAST_BIT)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy_amisha = (state_q != ST_IDLE);
    done_amisha = (state_q == ST_DONE);
  end

  // Datapath: operands are latched once at start; results only move when entering DONE.
  always_comb begin
    sr_a_d = sr_a_q;
    sr_b_d = sr_b_q;
    cnt_d  = cnt_q;
    eq_d   = eq_q;
    idx_d  = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start_amisha) begin
          sr_a_d = a_amisha;
          sr_b_d = b_amisha;
          cnt_d  = '0;
        end
      end
      ST_SHIFT: begin
        if (!bit_eq) begin
          eq_d  = 1'b0;
          idx_d = cnt_q;
        end else if (cnt_q == LAST_BIT) begin
          eq_d  = 1'b1;
          idx_d = '0;
        end else begin
          sr_a_d = sr_a_q >> 1;
          sr_b_d = sr_b_q >> 1;
          cnt_d  = cnt_q + IW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      sr_a_q <= '0;
      sr_b_q <= '0;
      cnt_q  <= '0;
      eq_q   <= 1'b0;
      idx_q  <= '0;
    end else begin
      sr_a_q <= sr_a_d;
      sr_b_q <= sr_b_d;
      cnt_q  <= cnt_d;
      eq_q   <= eq_d;
      idx_q  <= idx_d;
    end
  end

  assign eq_amisha  = eq_q;
  assign idx_amisha = idx_q;

endmodule

// File: tb/tb_eqn_serial_amisha.sv
// Directed plus random checks of the serial equality comparator against a plain-arithmetic model.
module tb_eqn_serial_amisha;

  localparam int N  = 8;
  localparam int IW = $clog2(N);

  logic          clk_amisha = 1'b0;
  logic          reset_amisha = 1'b1;
  logic          start_amisha = 1'b0;
  logic [N-1:0]  a_amisha = '0;
  logic [N-1:0]  b_amisha = '0;
  logic          busy_amisha;
  logic          done_amisha;
  logic          eq_amisha;
  logic [IW-1:0] idx_amisha;

  int n_total = 0;
  int n_pass  = 0;

  // Last result the bench expects to see on eq/idx (held between runs).
  bit exp_eq  = 1'b0;
  int exp_idx = 0;

  eqn_serial_amisha #(.N(N)) dut (
    .clk_amisha   (clk_amisha),
    .reset_amisha (reset_amisha),
    .start_amisha (start_amisha),
    .a_amisha     (a_amisha),
    .b_amisha     (b_amisha),
    .busy_amisha  (busy_amisha),
    .done_amisha  (done_amisha),
    .eq_amisha    (eq_amisha),
    .idx_amisha   (idx_amisha)
  );

  always #5 clk_amisha = ~clk_amisha;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected outcome from the comparison rules: lowest differing bit wins.
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                output int lat, output bit eq, output int idx);
    eq  = 1'b1;
    idx = 0;
    lat = N + 1;
    for (int i = N - 1; i >= 0; i--) begin
      if (a[i] != b[i]) begin
        eq  = 1'b0;
        idx = i;
        lat = i + 2;
      end
    end
  endfunction

  // Entered at the falling edge of cycle 0; returns at the falling edge of cycle lat+1.
  task automatic run_cmp(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit disturb, input bit busy_starts);
    int lat;
    bit r_eq;
    int r_idx;
    model(a, b, lat, r_eq, r_idx);
    a_amisha     = a;
    b_amisha     = b;
    start_amisha = 1'b1;
    @(posedge clk_amisha);
    #1 start_amisha = 1'b0;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk_amisha);
      if (c == lat + 1) begin
        exp_eq  = r_eq;
        exp_idx = r_idx;
      end
      chk({tag, "/busy"}, busy_amisha, (c <= lat));
      chk({tag, "/done"}, done_amisha, (c == lat));
      if (c == lat) begin
        chk({tag, "/eq"},  eq_amisha,  r_eq);
        chk({tag, "/idx"}, idx_amisha, r_idx);
      end else begin
        chk({tag, "/eq_hold"},  eq_amisha,  exp_eq);
        chk({tag, "/idx_hold"}, idx_amisha, exp_idx);
      end
      if (disturb && c == 2) begin
        a_amisha = N'($urandom);
        b_amisha = ~a_amisha;
      end
      if (busy_starts) begin
        if (c == 3 || c == lat) begin
          start_amisha = 1'b1;
          a_amisha     = N'(1);
          b_amisha     = '0;
        end else if (c == 4) begin
          start_amisha = 1'b0;
        end
      end
    end
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    int           lat;
    bit           r_eq;
    int           r_idx;

    repeat (2) @(posedge clk_amisha);
    @(negedge clk_amisha);
    chk("rst/busy", busy_amisha, 0);
    chk("rst/done", done_amisha, 0);
    chk("rst/eq",   eq_amisha,   0);
    chk("rst/idx",  idx_amisha,  0);
    reset_amisha = 1'b0;
    @(negedge clk_amisha);

    run_cmp("eq_a5",     8'hA5, 8'hA5, 1'b0, 1'b0);
    run_cmp("lsb_miss",  8'hA5, 8'hA4, 1'b0, 1'b0);
    run_cmp("msb_miss",  8'h80, 8'h00, 1'b0, 1'b0);
    run_cmp("busy_start", 8'h0F, 8'h0F, 1'b0, 1'b1);
    run_cmp("after_busy", 8'h3C, 8'h34, 1'b0, 1'b0);
    run_cmp("disturb",   8'h5A, 8'h5A, 1'b1, 1'b0);
    run_cmp("disturb_mm", 8'hC3, 8'hD3, 1'b1, 1'b0);

    // Reset in the middle of an equal compare: outputs clear at once and no done follows.
    a_amisha     = 8'h77;
    b_amisha     = 8'h77;
    start_amisha = 1'b1;
    @(posedge clk_amisha);
    #1 start_amisha = 1'b0;
    repeat (4) @(negedge clk_amisha);
    chk("mid/busy_pre", busy_amisha, 1);
    reset_amisha = 1'b1;
    #1;
    chk("mid/busy", busy_amisha, 0);
    chk("mid/done", done_amisha, 0);
    chk("mid/eq",   eq_amisha,   0);
    chk("mid/idx",  idx_amisha,  0);
    exp_eq  = 1'b0;
    exp_idx = 0;
    @(negedge clk_amisha);
    reset_amisha = 1'b0;
    begin
      int seen_done = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk_amisha);
        if (done_amisha === 1'b1 || busy_amisha === 1'b1) seen_done++;
      end
      chk("mid/no_done", seen_done, 0);
    end

    // Mix of equal, single-bit and random-difference operands.
    for (int t = 0; t < 40; t++) begin
      ra = N'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ N'(1 << $urandom_range(0, N - 1));
        default: rb = N'($urandom);
      endcase
      run_cmp("rand", ra, rb, ($urandom_range(0, 3) == 0), 1'b0);
    end

    model(8'h10, 8'h00, lat, r_eq, r_idx);
    chk("model/sanity_lat", lat, 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/eqn_serial_amisha.md
EQN_SERIAL_AMISHA -- requirements
Module: eqn_serial_amisha

Interface
REQ-001 Parameter: N, default 8, operand width in bits; SHALL be at least 2.
REQ-002 clk_amisha  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset_amisha  input  1  reset, asynchronous and active-high.
REQ-004 start_amisha  input  1  request a comparison; SHALL be sampled only in IDLE.
REQ-005 a_amisha  input  N  operand A; SHALL be captured on an accepted start.
REQ-006 b_amisha  input  N  operand B; SHALL be captured on an accepted start.
REQ-007 busy_amisha  output  1  high whenever state is not IDLE.
REQ-008 done_amisha  output  1  one-cycle pulse marking a valid result.
REQ-009 eq_amisha  output  1  result: 1 = A equals B; held until the next result.
REQ-010 idx_amisha  output  clog2(N)  index of the first mismatching bit, LSB first; 0 when equal.

Function
REQ-011 FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-012 IDLE: start_amisha=1 at an edge SHALL load both shift registers and clear the bit counter to 0, then go to SHIFT.
REQ-013 SHIFT: each cycle SHALL compare bit 0 of both shift registers through the 1-bit equality cell.
REQ-014 SHIFT mismatch SHALL write eq=0 and idx=counter, then go to DONE (early exit).
REQ-015 SHIFT match with counter=N-1 SHALL write eq=1 and idx=0, then go to DONE.
REQ-016 SHIFT match with counter<N-1 SHALL shift both registers right by one, increment the counter, and stay in SHIFT.
REQ-017 DONE SHALL assert done_amisha for exactly one cycle, then return to IDLE unconditionally.
REQ-018 Latency, with start sampled at the end of cycle 0: equal operands SHALL give done in cycle N+1; first mismatch at bit i SHALL give done in cycle i+2.
REQ-019 start_amisha SHALL be ignored in SHIFT and DONE; no queuing.
REQ-020 a_amisha/b_amisha changes after capture SHALL NOT affect the running comparison.
REQ-021 eq_amisha and idx_amisha SHALL change only on entry to DONE.
REQ-022 eq_amisha and idx_amisha SHALL otherwise hold their last values, including through IDLE.
REQ-023 Counter SHALL never exceed N-1; no wrap-around is possible.

Reset
REQ-024 reset_amisha=1 SHALL immediately, without waiting for a clock edge, force: state=IDLE, busy=0, done=0, eq=0, idx=0, counter=0, shift registers=0.
REQ-025 Reset asserted during SHIFT or DONE SHALL abort the comparison; no done pulse SHALL follow.
REQ-026 The first start SHALL be accepted at the first rising edge after reset deasserts.

Structure
REQ-027 Shared package eq_pkg_amisha SHALL hold the FSM state enum (IDLE/SHIFT/DONE) and the default width constant (8).
REQ-028 Per-bit compare SHALL be one instantiated sub-module, eq1_cell_amisha.
REQ-029 eq1_cell_amisha SHALL be purely combinational: 1-bit XNOR-equality.
REQ-030 All other logic (FSM, counter, shift registers, result registers) SHALL live in eqn_serial_amisha.

Verification (N=8)
REQ-031 Equal operands: a=0xA5, b=0xA5, start in cycle 0 -> busy cycles 1-9, done in cycle 9 only, eq=1, idx=0.
REQ-032 Mismatch at LSB: a=0xA5, b=0xA4 -> done in cycle 2, eq=0, idx=0.
REQ-033 Mismatch at MSB: a=0x80, b=0x00 -> done in cycle 9, eq=0, idx=7.
REQ-034 Start while busy: a=0x0F, b=0x0F accepted; new start with a=0x01, b=0x00 in cycles 3 and 9 -> single done in cycle 9, eq=1; start in cycle 10 is accepted.
REQ-035 Reset mid-run: reset asserted mid-cycle 4 of an equal compare -> busy, done, eq drop to 0 before the next edge; no done follows.
REQ-036 Input stability: a and b altered in cycle 2 of a run -> result still matches the operands captured at start.
